// File: rtl/ms_ff_bank.sv
// ms_ff_bank
//   Master-slave flip-flop bank. WIDTH independent bits share one runtime
//   mode (JK, SR, D or T). The master register updates on enabled clock
//   edges; the slave copies the master on every edge, so q lags the master
//   by one cycle. The bank also provides a sticky illegal-SR flag and a
//   one-cycle change-detect pulse.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          asynchronous active-high reset
//   en           master update enable
//   mode         2'b00 JK, 2'b01 SR, 2'b10 D, 2'b11 T
//   a            J / S / D / T per bit
//   b            K / R per bit (unused in D and T modes)
//   illegal_clr  clears the sticky illegal flag (set has priority)
//   q            slave register
//   qbar         ~q
//   illegal      sticky: an enabled SR edge saw S=R=1 on some bit
//   changed      one-cycle pulse after the slave takes a new value
module ms_ff_bank #(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             illegal_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             illegal,
  output logic             changed
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_SR = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] master_d, master_q;
  logic [WIDTH-1:0] slave_d, slave_q;
  logic [WIDTH-1:0] slave_prev_d, slave_prev_q;
  logic             illegal_d, illegal_q;
  logic             changed_d, changed_q;
  logic             sr_conflict;

  always_comb begin
    mode_sel = mode_e'(mode);
  end

  // Master next state, evaluated bitwise across the whole bank.
  always_comb begin
    master_d = master_q;
    if (en) begin
      unique case (mode_sel)
        MODE_JK: master_d = (a & ~master_q) | (~b & master_q);
        // S=R=1 holds: only a lone S sets and a lone R clears.
        MODE_SR: master_d = (a & ~b) | (master_q & ~(a ^ b));
        MODE_D:  master_d = a;
        MODE_T:  master_d = master_q ^ a;
        default: master_d = master_q;
      endcase
    end
  end

  always_comb begin
    slave_d      = master_q;
    slave_prev_d = slave_q;
  end

  // The previous slave value is kept in its own register so the pulse lands
  // one cycle after the slave itself changes; after reset both copies equal
  // RESET_VAL, which keeps the first post-reset cycle quiet.
  always_comb begin
    changed_d = (slave_q != slave_prev_q);
  end

  always_comb begin
    sr_conflict = en && (mode_sel == MODE_SR) && (|(a & b));
    illegal_d   = illegal_q;
    if (sr_conflict) begin
      illegal_d = 1'b1;
    end else if (illegal_clr) begin
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      master_q     <= RESET_VAL;
      slave_q      <= RESET_VAL;
      slave_prev_q <= RESET_VAL;
      illegal_q    <= 1'b0;
      changed_q    <= 1'b0;
    end else begin
      master_q     <= master_d;
      slave_q      <= slave_d;
      slave_prev_q <= slave_prev_d;
      illegal_q    <= illegal_d;
      changed_q    <= changed_d;
    end
  end

  assign q       = slave_q;
  assign qbar    = ~slave_q;
  assign illegal = illegal_q;
  assign changed = changed_q;

endmodule
